// File: rtl/spike_dispatch_unit_if.sv
// Handshake and data bundle between the spike dispatch unit and its neuron
// state memory / fired-tag FIFO environment.
interface spike_dispatch_unit_if #(
  parameter int numwidth = 16,
  parameter int tagbits  = 1
);
  logic                start;
  logic [numwidth:0]   v_in;
  logic [numwidth:0]   u_in;
  logic                fifo_full;
  logic [tagbits-1:0]  tag_out;
  logic                req_write_state;
  logic [numwidth:0]   v_out;
  logic [numwidth:0]   u_out;
  logic                req_enq;
  logic [tagbits-1:0]  enq_tag;
  logic [tagbits:0]    spike_count;
  logic                busy;
  logic                done;
  logic [5:0]          state;

  modport master (
    input  start, v_in, u_in, fifo_full,
    output tag_out, req_write_state, v_out, u_out, req_enq, enq_tag,
           spike_count, busy, done, state
  );

  modport slave (
    output start, v_in, u_in, fifo_full,
    input  tag_out, req_write_state, v_out, u_out, req_enq, enq_tag,
           spike_count, busy, done, state
  );
endinterface

// File: rtl/spike_dispatch_unit.sv
// Sweeps all neuron tags after an update epoch, applies the Izhikevich reset
// to neurons at or above vpeak, writes them back and enqueues their tags.
module spike_dispatch_unit #(
  parameter int numneurons = 2,
  parameter int numwidth   = 16,
  parameter int tagbits    = 1,
  parameter int vpeak      = 30,
  parameter int c_reset    = -65,
  parameter int d_inc      = 8
) (
  input  logic                  clk,
  input  logic                  asyn_reset_n,
  spike_dispatch_unit_if.master bus
);

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    READ    = 6'b000010,
    COMPARE = 6'b000100,
    WRITE   = 6'b001000,
    ENQ     = 6'b010000,
    DONE    = 6'b100000
  } state_t;

  localparam logic signed [numwidth:0]   vpeak_c  = (numwidth+1)'(vpeak);
  localparam logic signed [numwidth:0]   c_val    = (numwidth+1)'(c_reset);
  localparam logic signed [numwidth+1:0] d_val    = (numwidth+2)'(d_inc);
  localparam logic signed [numwidth:0]   u_max    = {1'b0, {numwidth{1'b1}}};
  localparam logic signed [numwidth:0]   u_min    = {1'b1, {numwidth{1'b0}}};
  localparam logic [tagbits-1:0]         last_tag = tagbits'(numneurons - 1);

  state_t                     state_q, state_d;
  logic [tagbits-1:0]         tag;
  logic [tagbits:0]           spike_count;
  logic signed [numwidth:0]   cur_v, cur_u;
  logic signed [numwidth+1:0] u_sum;
  logic signed [numwidth:0]   u_sat;
  logic                       fire, last, advance;

  assign fire    = cur_v >= vpeak_c;
  assign last    = (tag == last_tag);
  // Sweep termination is by count, so non-power-of-2 neuron counts never wrap.
  assign advance = ((state_q == COMPARE) && !fire) ||
                   ((state_q == ENQ) && !bus.fifo_full);

  // One guard bit detects overflow; the guard's sign picks the rail.
  always_comb begin
    u_sum = {cur_u[numwidth], cur_u} + d_val;
    u_sat = u_sum[numwidth:0];
    if (u_sum[numwidth+1] != u_sum[numwidth])
      u_sat = u_sum[numwidth+1] ? u_min : u_max;
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    state_d = COMPARE;
      COMPARE: if (fire) state_d = WRITE;
               else      state_d = last ? DONE : READ;
      WRITE:   state_d = ENQ;
      ENQ:     if (!bus.fifo_full) state_d = last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      tag         <= '0;
      spike_count <= '0;
      cur_v       <= '0;
      cur_u       <= '0;
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        tag         <= '0;
        spike_count <= '0;
      end
      if (state_q == READ) begin
        cur_v <= bus.v_in;
        cur_u <= bus.u_in;
      end
      if ((state_q == ENQ) && !bus.fifo_full)
        spike_count <= spike_count + (tagbits+1)'(1);
      if (advance && !last)
        tag <= tag + tagbits'(1);
    end
  end

  assign bus.tag_out     = tag;
  assign bus.spike_count = spike_count;
  assign bus.state       = state_q;

  always_comb begin
    bus.busy            = (state_q != IDLE);
    bus.done            = (state_q == DONE);
    bus.req_write_state = 1'b0;
    bus.v_out           = '0;
    bus.u_out           = '0;
    bus.req_enq         = 1'b0;
    bus.enq_tag         = '0;
    if (state_q == WRITE) begin
      bus.req_write_state = 1'b1;
      bus.v_out           = c_val;
      bus.u_out           = u_sat;
    end
    if (state_q == ENQ) begin
      bus.enq_tag = tag;
      bus.req_enq = !bus.fifo_full;
    end
  end

endmodule

// File: tb/tb_spike_dispatch_unit.sv
// Directed bench for spike_dispatch_unit: state memory model, write/enqueue
// logs and per-scenario checks with hand-computed expectations.
module tb_spike_dispatch_unit;
  localparam int NW    = 15;
  localparam int TBITS = 2;
  localparam int N     = 4;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_READ  = 6'b000010;
  localparam logic [5:0] S_WRITE = 6'b001000;
  localparam logic [5:0] S_ENQ   = 6'b010000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_dispatch_unit_if #(.numwidth(NW), .tagbits(TBITS)) bus();

  spike_dispatch_unit #(
    .numneurons(N), .numwidth(NW), .tagbits(TBITS),
    .vpeak(30), .c_reset(-65), .d_inc(8)
  ) dut (
    .clk(clk),
    .asyn_reset_n(rst_n),
    .bus(bus.master)
  );

  logic signed [NW:0] vm[N], um[N], vinit[N], uinit[N];
  logic load_req = 1'b0;

  assign bus.v_in = vm[bus.tag_out];
  assign bus.u_in = um[bus.tag_out];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        vm[i] <= vinit[i];
        um[i] <= uinit[i];
      end
    end else if (bus.req_write_state) begin
      vm[bus.tag_out] <= bus.v_out;
      um[bus.tag_out] <= bus.u_out;
    end
  end

  int unsigned        wtag[$];
  logic signed [NW:0] wv[$], wu[$];
  int unsigned        etag[$];
  int                 both_cnt = 0;

  always @(negedge clk) begin
    if (bus.req_write_state) begin
      wtag.push_back(int'(bus.tag_out));
      wv.push_back(bus.v_out);
      wu.push_back(bus.u_out);
    end
    if (bus.req_enq) etag.push_back(int'(bus.enq_tag));
    if (bus.req_write_state && bus.req_enq) both_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic load(input logic signed [NW:0] v0, v1, v2, v3,
                      input logic signed [NW:0] u0, u1, u2, u3);
    vinit[0] = v0; vinit[1] = v1; vinit[2] = v2; vinit[3] = v3;
    uinit[0] = u0; uinit[1] = u1; uinit[2] = u2; uinit[3] = u3;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(output int cyc);
    cyc = 0;
    bus.start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {bus.busy, bus.done, bus.req_write_state, bus.req_enq, bus.tag_out,
            bus.enq_tag, bus.spike_count, bus.v_out, bus.u_out};
  endfunction

  task automatic test_reset();
    bus.start = 1'b0;
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.state !== S_IDLE) begin
      fails++; $display("FAIL reset_state: got %b want %b", bus.state, S_IDLE);
    end
    tests++;
    if (outs_vec() !== 64'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", outs_vec());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_fire();
    int cyc, w0, e0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    w0 = wtag.size(); e0 = etag.size();
    sweep(cyc);
    tests++;
    if (cyc !== 9) begin
      fails++; $display("FAIL nofire_done_cycle: got %0d want 9", cyc);
    end
    tests++;
    if (bus.spike_count !== 3'd0) begin
      fails++; $display("FAIL nofire_count: got %0d want 0", bus.spike_count);
    end
    tests++;
    if (wtag.size() != w0 || etag.size() != e0) begin
      fails++; $display("FAIL nofire_activity: got %0d writes %0d enq want 0 0",
                        wtag.size() - w0, etag.size() - e0);
    end
    @(negedge clk);
    tests++;
    if (bus.state !== S_IDLE || bus.busy !== 1'b0) begin
      fails++; $display("FAIL nofire_idle: got state %b busy %b want %b 0",
                        bus.state, bus.busy, S_IDLE);
    end
  endtask

  task automatic test_fire();
    int cyc, w0, e0;
    load(30, 29, 100, -70, 2, 0, -5, 0);
    w0 = wtag.size(); e0 = etag.size();
    sweep(cyc);
    tests++;
    if (cyc !== 13) begin
      fails++; $display("FAIL fire_done_cycle: got %0d want 13", cyc);
    end
    tests++;
    if (bus.spike_count !== 3'd2 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL fire_count_busy: got %0d/%b want 2/1", bus.spike_count, bus.busy);
    end
    tests++;
    if (wtag.size() != w0 + 2 || wtag[w0] != 0 || wtag[w0+1] != 2 ||
        wv[w0] !== -65 || wv[w0+1] !== -65 || wu[w0] !== 10 || wu[w0+1] !== 3) begin
      fails++; $display("FAIL fire_writes: got n=%0d t=%0d,%0d v=%0d,%0d u=%0d,%0d want n=2 t=0,2 v=-65,-65 u=10,3",
                        wtag.size() - w0, wtag[w0], wtag[w0+1], wv[w0], wv[w0+1], wu[w0], wu[w0+1]);
    end
    tests++;
    if (etag.size() != e0 + 2 || etag[e0] != 0 || etag[e0+1] != 2) begin
      fails++; $display("FAIL fire_enq_order: got n=%0d %0d,%0d want n=2 0,2",
                        etag.size() - e0, etag[e0], etag[e0+1]);
    end
    tests++;
    if (vm[0] !== -65 || um[0] !== 10 || vm[1] !== 29 || vm[2] !== -65 || um[2] !== 3) begin
      fails++; $display("FAIL fire_memory: got v0=%0d u0=%0d v1=%0d v2=%0d u2=%0d want -65 10 29 -65 3",
                        vm[0], um[0], vm[1], vm[2], um[2]);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.spike_count !== 3'd2) begin
      fails++; $display("FAIL fire_count_hold: got busy %b count %0d want 0 2", bus.busy, bus.spike_count);
    end
  endtask

  task automatic test_stall();
    int cyc, e0, bad;
    load(30, 29, 100, -70, 2, 0, -5, 0);
    e0 = etag.size();
    cyc = 0; bad = 0;
    bus.start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 3) begin
        tests++;
        if (bus.state !== S_WRITE) begin
          fails++; $display("FAIL stall_write_state: got %b want %b", bus.state, S_WRITE);
        end
        bus.fifo_full = 1'b1;
      end
      if (k >= 4 && k <= 8) begin
        if (bus.state !== S_ENQ || bus.req_enq !== 1'b0 || bus.tag_out !== 2'd0 ||
            bus.enq_tag !== 2'd0) bad++;
      end
      if (k == 9) begin
        tests++;
        if (bus.req_enq !== 1'b1 || bus.enq_tag !== 2'd0) begin
          fails++; $display("FAIL stall_release_enq: got req %b tag %0d want 1 0", bus.req_enq, bus.enq_tag);
        end
      end
      if (bus.done) begin
        cyc = k;
        break;
      end
      if (k == 8) begin
        @(posedge clk);
        #1 bus.fifo_full = 1'b0;
      end
    end
    bus.fifo_full = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    end
    tests++;
    if (cyc !== 18) begin
      fails++; $display("FAIL stall_done_cycle: got %0d want 18", cyc);
    end
    tests++;
    if (etag.size() != e0 + 2 || etag[e0] != 0 || etag[e0+1] != 2 || bus.spike_count !== 3'd2) begin
      fails++; $display("FAIL stall_enq: got n=%0d %0d,%0d count %0d want n=2 0,2 count 2",
                        etag.size() - e0, etag[e0], etag[e0+1], bus.spike_count);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int cyc, w0;
    load(40, -1, 0, 0, 16'sd32760, 0, 0, 0);
    w0 = wtag.size();
    sweep(cyc);
    tests++;
    if (cyc !== 11 || bus.spike_count !== 3'd1) begin
      fails++; $display("FAIL sat_done: got cycle %0d count %0d want 11 1", cyc, bus.spike_count);
    end
    tests++;
    if (wtag.size() != w0 + 1 || wu[w0] !== 16'sd32767 || wtag[w0] != 0) begin
      fails++; $display("FAIL sat_u_out: got n=%0d tag %0d u %0d want n=1 tag 0 u 32767",
                        wtag.size() - w0, wtag[w0], wu[w0]);
    end
    tests++;
    if (vm[0] !== -65 || um[0] !== 16'sd32767 || vm[1] !== -1) begin
      fails++; $display("FAIL sat_memory: got v0=%0d u0=%0d v1=%0d want -65 32767 -1",
                        vm[0], um[0], vm[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int cyc, k, w0, e0;
    load(0, 50, 0, 0, 0, 7, 0, 0);
    bus.start = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.state === S_WRITE) begin
        k = i;
        break;
      end
    end
    tests++;
    if (k !== 5 || bus.tag_out !== 2'd1) begin
      fails++; $display("FAIL midrst_write_reached: got cycle %0d tag %0d want 5 1", k, bus.tag_out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.state !== S_IDLE || outs_vec() !== 64'd0) begin
      fails++; $display("FAIL midrst_async: got state %b outs %h want %b 0", bus.state, outs_vec(), S_IDLE);
    end
    @(negedge clk);
    tests++;
    if (bus.state !== S_IDLE || outs_vec() !== 64'd0 || vm[1] !== 50) begin
      fails++; $display("FAIL midrst_next_cycle: got state %b outs %h v1 %0d want %b 0 50",
                        bus.state, outs_vec(), vm[1], S_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wtag.size(); e0 = etag.size();
    sweep(cyc);
    tests++;
    if (cyc !== 11 || bus.spike_count !== 3'd1) begin
      fails++; $display("FAIL midrst_resweep: got cycle %0d count %0d want 11 1", cyc, bus.spike_count);
    end
    tests++;
    if (wtag.size() != w0 + 1 || wtag[w0] != 1 || etag.size() != e0 + 1 || etag[e0] != 1 ||
        vm[1] !== -65 || um[1] !== 15) begin
      fails++; $display("FAIL midrst_resweep_data: got w=%0d e=%0d v1=%0d u1=%0d want 1 1 -65 15",
                        wtag.size() - w0, etag.size() - e0, vm[1], um[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int k1, k2;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    k1 = 0; k2 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        k1 = k;
        break;
      end
    end
    tests++;
    if (k1 !== 9) begin
      fails++; $display("FAIL held_first_done: got %0d want 9", k1);
    end
    @(negedge clk);
    tests++;
    if (bus.state !== S_IDLE || bus.busy !== 1'b0) begin
      fails++; $display("FAIL held_idle_gap: got state %b busy %b want %b 0", bus.state, bus.busy, S_IDLE);
    end
    @(negedge clk);
    tests++;
    if (bus.state !== S_READ || bus.tag_out !== 2'd0) begin
      fails++; $display("FAIL held_restart: got state %b tag %0d want %b 0", bus.state, bus.tag_out, S_READ);
    end
    bus.start = 1'b0;
    for (int k = 12; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        k2 = k;
        break;
      end
    end
    tests++;
    if (k2 !== 19) begin
      fails++; $display("FAIL held_second_done: got %0d want 19", k2);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_no_fire();
    test_fire();
    test_stall();
    test_saturate();
    test_reset_mid_write();
    test_start_held();
    tests++;
    if (both_cnt != 0) begin
      fails++; $display("FAIL write_enq_exclusive: got %0d overlaps want 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
